div: RTL and testbench
======================

# div

Multi-cycle 32-bit integer divider for the core's execute stage, serving DIV and DIVU. EX starts a division, stalls the pipeline while it runs, then consumes the 64-bit {remainder, quotient} result. EX writes that result to HI/LO through the existing whilo/hi/lo path. It is a restoring divider producing one quotient bit per cycle, and it supports cancellation when EX is flushed.

## Interface
Parameters: none. Widths are fixed at 32-bit operands and a 64-bit result.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high (`RstEnable); single clock domain
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  in  32  dividend; sampled with start_i
- opdata2_i  in  32  divisor; sampled with start_i
- start_i  in  1  request a division; level, held high by EX until it has consumed the result
- annul_i  in  1  cancel the operation in flight (pipeline flush)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1
- ready_o  out  1  result valid

## Operation
The block has four states: FREE, BYZERO, ON and END. Outputs are registered.

- **FREE**
  - start_i=1, annul_i=0, opdata2_i≠0 → ON. Latch the absolute values of the operands. Latch the sign info (signed_div_i, opdata1_i[31], opdata2_i[31]). Clear the step counter.
  - start_i=1, annul_i=0, opdata2_i=0 → BYZERO.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- **Operand conditioning:** when signed_div_i=1, a negative operand is replaced by its two's complement. When signed_div_i=0, operands are used raw.
- **ON**
  - Each cycle computes one quotient bit, MSB first: trial = partial_remainder_shifted − divisor (33-bit). A nonnegative trial gives a quotient bit of 1 and keeps the difference. A negative trial gives a quotient bit of 0 and keeps the shifted remainder.
  - The counter runs 0..31. After step 31 the block goes to END.
  - annul_i=1 in any ON cycle → FREE; no result is produced.
- **BYZERO**
  - Goes to END next cycle with result 0.
  - annul_i=1 → FREE.
- **END**
  - ready_o=1.
  - When signed, the quotient is negated if the operand signs differ, and the remainder is negated if the dividend was negative.
  - result_o = {rem, quo}.
  - The block stays in END while start_i=1. When start_i=0 it goes to FREE, and ready_o=0 and result_o=0 next cycle.
  - annul_i is ignored in END.
- **Input changes:** operand or signed_div_i changes after the start cycle have no effect. start_i is ignored outside FREE.
- **Overflow:** 0x80000000 / 0xFFFFFFFF signed is not trapped. It yields quotient 0x80000000, remainder 0 (modulo-2^32 wrap).
- **Reset:** rst=1 in any state, including mid-operation → FREE, counter 0, ready_o=0, result_o=0 at the next edge.

## Timing
- Start is sampled at edge T, which means start_i=1 in the cycle before T.
- Normal division: ON occupies cycles T..T+31, END is entered at edge T+32, and ready_o=1 from T+32 onward. That is 33 cycles from start_i assertion to ready_o.
- Divide by zero: BYZERO at T, END at T+1, ready_o=1 from T+1.
- Release: start_i dropped in cycle E → ready_o=0 after edge E.
  - A new start may be presented in the cycle after ready_o falls.
  - Back-to-back issue costs 1 idle FREE cycle.
- Annul: annul_i=1 in cycle A while in ON or BYZERO → FREE after edge A. ready_o never rises for that operation.
- Annul and start together: annul_i=1 with start_i=1 in FREE → the start is not accepted.

## Test plan
- **Unsigned divide:** DIVU 100 / 7, start held → ready_o rises exactly 33 cycles after start; result_o = 0x00000002_0000000E. result_o holds while start_i=1, and ready_o=0 the cycle after start_i drops.
- **Signed divide:** DIV −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat with 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- **Divide by zero:** any dividend / 0, signed and unsigned → ready_o=1 two cycles after start, result_o=0.
- **Annul:** pulse annul_i at step 10 of a DIVU 0xFFFFFFFF / 3 → ready_o stays 0 and the block is in FREE next cycle. A fresh DIVU 9 / 3 then returns 0x00000000_00000003 with full 33-cycle latency.
- **Corner operands:** DIV 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000. DIVU 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF. DIVU 5 / 9 → 0x00000005_00000000.
- **Reset and input stability:** assert rst at step 20 → all outputs 0 next cycle and the next start behaves normally. Change the operands mid-ON → the result reflects the originally latched operands.

Source files
------------

// File: rtl/div.sv
// Restoring 32-bit divider for the execute stage (DIV/DIVU), one quotient bit per cycle.
// Result {remainder, quotient} is held on result_o with ready_o while start_i stays high.
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic [4:0]  cnt_reg;
   logic [31:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] dvs_reg;
   logic        sgn_reg;
   logic        neg1_reg;
   logic        neg2_reg;
   logic [63:0] result_reg, result_next;
   logic        ready_reg, ready_next;

   logic [31:0] op1_abs;
   logic [31:0] op2_abs;
   logic [32:0] shifted;
   logic [32:0] dvs_ext;
   logic        q_bit;
   logic [31:0] rem_step;
   logic [31:0] quo_step;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic        accept;

   // Magnitudes only for signed ops; 0x80000000 stays 0x80000000, which is its correct unsigned magnitude.
   assign op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   assign accept  = start_i && !annul_i;

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   assign shifted  = {rem_reg, quo_reg[31]};
   assign dvs_ext  = {1'b0, dvs_reg};
   assign q_bit    = (shifted >= dvs_ext);
   assign rem_step = q_bit ? 32'(shifted - dvs_ext) : shifted[31:0];
   assign quo_step = {quo_reg[30:0], q_bit};

   assign quo_fix  = (sgn_reg && (neg1_reg ^ neg2_reg)) ? (~quo_step + 32'd1) : quo_step;
   assign rem_fix  = (sgn_reg && neg1_reg) ? (~rem_step + 32'd1) : rem_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_FREE;
         cnt_reg    <= 5'd0;
         rem_reg    <= 32'd0;
         quo_reg    <= 32'd0;
         dvs_reg    <= 32'd0;
         sgn_reg    <= 1'b0;
         neg1_reg   <= 1'b0;
         neg2_reg   <= 1'b0;
         result_reg <= 64'd0;
         ready_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         result_reg <= result_next;
         ready_reg  <= ready_next;
         case (state_reg)
            S_FREE: begin
               if (accept && (opdata2_i != 32'd0)) begin
                  rem_reg  <= 32'd0;
                  quo_reg  <= op1_abs;
                  dvs_reg  <= op2_abs;
                  sgn_reg  <= signed_div_i;
                  neg1_reg <= opdata1_i[31];
                  neg2_reg <= opdata2_i[31];
                  cnt_reg  <= 5'd0;
               end
            end
            S_ON: begin
               rem_reg <= rem_step;
               quo_reg <= quo_step;
               cnt_reg <= cnt_reg + 5'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FREE:   if (accept) state_next = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
         S_BYZERO: state_next = annul_i ? S_FREE : S_END;
         S_ON: begin
            if (annul_i)               state_next = S_FREE;
            else if (cnt_reg == 5'd31) state_next = S_END;
         end
         S_END:    state_next = start_i ? S_END : S_FREE;
         default:  state_next = S_FREE;
      endcase
   end

   // Result is captured once on entry to END and held until release; zero everywhere else.
   always_comb begin
      ready_next  = (state_next == S_END);
      result_next = 64'd0;
      if (state_reg == S_ON && state_next == S_END)
         result_next = {rem_fix, quo_fix};
      else if (state_reg == S_END && state_next == S_END)
         result_next = result_reg;
   end

   assign result_o = result_reg;
   assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random operands
// compared against plain-arithmetic division.
module tb_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_checks = 0;
   int n_fail   = 0;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: 64-bit arithmetic, truncating division; wraps the signed overflow case naturally.
   function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return 64'd0;
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one division from a negedge in FREE, measure latency, check hold/annul-ignore/release.
   task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input string tag);
      logic [63:0] exp;
      int lat;
      int exp_lat;
      exp = ref_div(sg, a, b);
      exp_lat = (b == 32'd0) ? 2 : 33;
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      annul_i      = 1'b0;
      start_i      = 1'b1;
      lat = 0;
      while (!ready_o && lat < 40) begin
         @(negedge clk);
         lat++;
         if (scramble && lat == 1) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~sg;
         end
      end
      check({tag, " latency"}, 65'(lat), 65'(exp_lat));
      check({tag, " result"}, {ready_o, result_o}, {1'b1, exp});
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      check({tag, " hold1"}, {ready_o, result_o}, {1'b1, exp});
      @(negedge clk);
      check({tag, " hold2"}, {ready_o, result_o}, {1'b1, exp});
      start_i = 1'b0;
      @(negedge clk);
      check({tag, " release"}, {ready_o, result_o}, 65'd0);
      $display("div sg=%0d a=%h b=%h -> %h lat=%0d", sg, a, b, exp, lat);
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit rs;
      rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
      start_i = 1'b0; annul_i = 1'b0;
      repeat (3) @(negedge clk);
      check("reset outputs", {ready_o, result_o}, 65'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle outputs", {ready_o, result_o}, 65'd0);

      run_div(1'b0, 32'd100, 32'd7, 1'b0, "divu 100/7");
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, "div -7/2");
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, "div 7/-2");
      run_div(1'b0, 32'd1234, 32'd0, 1'b0, "divu by zero");
      run_div(1'b1, 32'h80000000, 32'd0, 1'b0, "div by zero");
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div overflow");
      run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, "divu max/1");
      run_div(1'b0, 32'd5, 32'd9, 1'b0, "divu 5/9");

      // Annul at step 10 of a long division.
      signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3;
      start_i = 1'b1; annul_i = 1'b0;
      repeat (11) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;
      check("annul outputs", {ready_o, result_o}, 65'd0);
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (ready_o) break;
      end
      check("annul no ready", {64'd0, ready_o}, 65'd0);
      run_div(1'b0, 32'd9, 32'd3, 1'b0, "divu after annul");

      // Start together with annul in FREE is refused.
      signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd0;
      start_i = 1'b1; annul_i = 1'b1;
      repeat (3) @(negedge clk);
      check("start+annul refused", {64'd0, ready_o}, 65'd0);
      run_div(1'b0, 32'd50, 32'd6, 1'b0, "divu after refused start");

      // Reset at step 20.
      signed_div_i = 1'b1; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd77;
      start_i = 1'b1; annul_i = 1'b0;
      repeat (21) @(negedge clk);
      rst = 1'b1; start_i = 1'b0;
      @(negedge clk);
      check("mid-op reset", {ready_o, result_o}, 65'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post-reset idle", {ready_o, result_o}, 65'd0);
      run_div(1'b1, 32'hDEADBEEF, 32'd77, 1'b0, "div after reset");

      // Operands changing mid-ON must not disturb the latched ones.
      run_div(1'b1, 32'hC0000001, 32'h00012345, 1'b1, "div scrambled");
      run_div(1'b0, 32'hC0000001, 32'h00012345, 1'b1, "divu scrambled");

      for (int k = 0; k < 30; k++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFFFFFF - $urandom_range(0, 15);
            default: rb = $urandom;
         endcase
         run_div(rs, ra, rb, 1'($urandom_range(0, 1)), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
